// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: opcodes, FSM states and requester ID type for the ALU arbiter
package alu_arb_pkg;
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDC  = 5'd1;
    localparam logic [4:0] OP_SUBBA = 5'd2;
    localparam logic [4:0] OP_SUBAB = 5'd3;
    localparam logic [4:0] OP_INC   = 5'd4;
    localparam logic [4:0] OP_DEC   = 5'd5;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef logic id_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; pointer names the requester favoured on contention
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic r_ptr;
    assign grant[0] = req[0] & (~req[1] | ~r_ptr);
    assign grant[1] = req[1] & (~req[0] | r_ptr);
    // after a grant, favour the requester that was not granted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ptr <= 1'b0;
        else if (advance) r_ptr <= grant[0];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto a shared combinational ALU; ALU_ARB_CARRY_EN adds per-requester carry flags
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_fsec,
    output logic             alu_carry,
    input  logic [WIDTH-1:0] alu_fout,
    output logic             busy
);
    state_t           r_state;
    logic [1:0]       w_grant;
    logic             w_hs;
    id_t              w_id;
    logic [OPW-1:0]   w_op;
    logic [WIDTH-1:0] w_a, w_b;
    logic [WIDTH-1:0] r_alu_a, r_alu_b, r_resp_data;
    logic [OPW-1:0]   r_alu_fsec;
    id_t              r_id;
    logic             r_resp_carry;
    logic             w_cout;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (w_hs),
        .grant   (w_grant)
    );

    assign req0_ready = (r_state == IDLE) & w_grant[0];
    assign req1_ready = (r_state == IDLE) & w_grant[1];
    assign w_hs       = req0_ready | req1_ready;
    assign w_id       = w_grant[1];
    assign w_op       = w_id ? req1_op : req0_op;
    assign w_a        = w_id ? req1_a : req0_a;
    assign w_b        = w_id ? req1_b : req0_b;

`ifdef ALU_ARB_CARRY_EN
    logic [1:0] r_flag;
    logic       r_alu_carry;
    logic       w_is_add;
    assign w_is_add  = (r_alu_fsec == OP_ADD) | (r_alu_fsec == OP_ADDC);
    assign w_cout    = w_is_add & ((alu_fout < r_alu_a) | (r_alu_carry & (alu_fout == r_alu_a)));
    assign alu_carry = r_alu_carry;
    // ADDC consumes the issuer's flag at issue; add results refresh that flag in EXEC
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_flag      <= 2'b00;
            r_alu_carry <= 1'b0;
        end else if (w_hs) begin
            r_alu_carry <= (w_op == OP_ADDC) & r_flag[w_id];
        end else if (r_state == EXEC && w_is_add) begin
            r_flag[r_id] <= w_cout;
        end
`else
    assign w_cout    = 1'b0;
    assign alu_carry = 1'b0;
`endif

    // IDLE -> EXEC on handshake, EXEC captures the ALU, RESP waits for the consumer
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state      <= IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_fsec   <= '0;
            r_id         <= 1'b0;
            r_resp_data  <= '0;
            r_resp_carry <= 1'b0;
        end else if (w_hs) begin
            r_alu_a    <= w_a;
            r_alu_b    <= w_b;
            r_alu_fsec <= w_op;
            r_id       <= w_id;
            r_state    <= EXEC;
        end else if (r_state == EXEC) begin
            r_resp_data  <= alu_fout;
            r_resp_carry <= w_cout;
            r_state      <= RESP;
        end else if (r_state == RESP && resp_ready) begin
            r_state <= IDLE;
        end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_fsec   = r_alu_fsec;
    assign resp_valid = r_state == RESP;
    assign resp_id    = r_id;
    assign resp_data  = r_resp_data;
    assign resp_carry = r_resp_carry;
    assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    import alu_arb_pkg::*;
    logic        clk = 0, rst_n = 0;
    logic        req0_valid = 0, req1_valid = 0, resp_ready = 1;
    logic        req0_ready, req1_ready, resp_valid, resp_id, resp_carry, alu_carry, busy;
    logic [4:0]  req0_op = 0, req1_op = 0, alu_fsec;
    logic [63:0] req0_a = 0, req1_a = 0, req0_b = 0, req1_b = 0;
    logic [63:0] resp_data, alu_a, alu_b, alu_fout;
    int          n_vec = 0, n_err = 0, cyc = 0;
    logic [1:0]  flag = 2'b00;
    typedef struct { logic id; logic [63:0] data; logic carry; } exp_t;
    exp_t        q[$];

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_carry(resp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fsec(alu_fsec), .alu_carry(alu_carry),
        .alu_fout(alu_fout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] alu_f(logic [4:0] op, logic [63:0] a, logic [63:0] b, logic c);
        case (op)
            OP_ADD:   return a + b;
            OP_ADDC:  return a + b + {63'd0, c};
            OP_SUBBA: return b - a;
            OP_SUBAB: return a - b;
            OP_INC:   return a + 64'd1;
            OP_DEC:   return a - 64'd1;
            default:  return a ^ b;
        endcase
    endfunction

    assign alu_fout = alu_f(alu_fsec, alu_a, alu_b, alu_carry);

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push_exp(logic id, logic [4:0] op, logic [63:0] a, logic [63:0] b);
        exp_t e;
        logic cin;
        cin = 1'b0;
`ifdef ALU_ARB_CARRY_EN
        cin = (op == OP_ADDC) & flag[id];
`endif
        e.id = id;
        e.data = alu_f(op, a, b, cin);
        e.carry = 1'b0;
`ifdef ALU_ARB_CARRY_EN
        if (op == OP_ADD || op == OP_ADDC) begin
            e.carry = (e.data < a) | (cin & (e.data == a));
            flag[id] = e.carry;
        end
`endif
        q.push_back(e);
    endtask

    task automatic set_req(logic id, logic v, logic [4:0] op, logic [63:0] a, logic [63:0] b);
        if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
        else begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    endtask

    task automatic issue(logic id, logic [4:0] op, logic [63:0] a, logic [63:0] b);
        logic got;
        got = 0;
        set_req(id, 1'b1, op, a, b);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chk("issue_hs", got, 1);
        if (got) push_exp(id, op, a, b);
        @(posedge clk); #1;
        set_req(id, 1'b0, op, a, b);
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        chk("wait_idle", idle, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_fsec"}, alu_fsec, 0);
        chk({tag, "_alu_carry"}, alu_carry, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_resp_carry"}, resp_carry, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // scoreboard: every accepted response must match the oldest expected entry
    always @(negedge clk)
        if (rst_n && resp_valid && resp_ready) begin
            chk("resp_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("resp_id", resp_id, e.id);
                chk("resp_data", resp_data, e.data);
                chk("resp_carry", resp_carry, e.carry);
            end
        end

    initial begin
        int k, last;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst_n = 1;

        set_req(0, 1'b1, OP_ADD, 64'd1, 64'd2);
        set_req(1, 1'b1, OP_SUBAB, 64'd10, 64'd3);
        k = 0;
        last = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (req0_ready | req1_ready) begin
                chk("cont_grant", req1_ready, k % 2);
                chk("cont_onehot", req0_ready ^ req1_ready, 1);
                if (k > 0) chk("cont_interval", cyc - last, 3);
                last = cyc;
                if (k % 2 == 0) push_exp(0, OP_ADD, 64'd1, 64'd2);
                else push_exp(1, OP_SUBAB, 64'd10, 64'd3);
                k++;
            end
        end
        chk("cont_count", k, 4);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        wait_idle();

        issue(0, OP_ADD, 64'd5, 64'd7);
        @(negedge clk);
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 7);
        chk("add_alu_fsec", alu_fsec, OP_ADD);
        chk("add_exec_busy", busy, 1);
        chk("add_exec_rv", resp_valid, 0);
        @(negedge clk);
        chk("add_n2_rv", resp_valid, 1);
        chk("add_n2_data", resp_data, 12);
        chk("add_n2_id", resp_id, 0);
        wait_idle();

        issue(1, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        resp_ready = 0;
        set_req(0, 1'b1, OP_INC, 64'd1, 64'd0);
        set_req(1, 1'b1, OP_INC, 64'd2, 64'd0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rv", resp_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_rdy", {req1_ready, req0_ready}, 0);
            chk("bp_data", resp_data, 0);
            chk("bp_id", resp_id, 1);
        end
        @(posedge clk); #1;
        resp_ready = 1;
        req0_valid = 0;
        req1_valid = 0;
        wait_idle();

        issue(1, OP_ADDC, 64'd0, 64'd0);
        wait_idle();
        issue(0, OP_ADD, 64'd3, 64'd4);
        wait_idle();
        issue(0, OP_ADDC, 64'd0, 64'd0);
        wait_idle();
        issue(0, OP_DEC, 64'd0, 64'd0);
        wait_idle();
        issue(1, 5'd7, 64'hF0F0, 64'h0FF0);
        @(negedge clk);
        chk("pass_fsec", alu_fsec, 7);
        wait_idle();

        issue(0, OP_ADD, 64'd9, 64'd9);
        #2 rst_n = 0;
        void'(q.pop_back());
        flag = 2'b00;
        @(negedge clk);
        chk_zero("rst_exec");
        chk("rst_rdy", {req1_ready, req0_ready}, 0);
        @(posedge clk); #1 rst_n = 1;
        set_req(0, 1'b1, OP_SUBBA, 64'd4, 64'd20);
        set_req(1, 1'b1, OP_ADD, 64'd1, 64'd1);
        @(negedge clk);
        chk("rst_ptr_r0", req0_ready, 1);
        chk("rst_ptr_r1", req1_ready, 0);
        push_exp(0, OP_SUBBA, 64'd4, 64'd20);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
        wait_idle();

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
